// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx -- transmit-only UART behind an AHB-Lite slave port.
//
// Bus writes to DATA push bytes into a small TX FIFO. A serializer drains the
// FIFO as 8N1 frames (start bit, 8 data bits LSB first, stop bit) on o_txd.
// Frames run back to back while the FIFO holds data.
//
// Register map (HADDR[3:2]):
//   0x0 DATA     W: push HWDATA[7:0]           R: 0
//   0x4 STATUS   R: [0] FULL [1] EMPTY [2] BUSY [3] OVERFLOW [15:8] count
//                W: bit3=1 clears OVERFLOW
//   0x8 BAUDDIV  R/W [15:0]; bit period = BAUDDIV+1 HCLK cycles
//   0xC CTRL     only with AHB_UART_TX_IRQ_EN: [0] TXDONE_IE [1] OVF_IE;
//                otherwise unmapped (reads 0, writes ignored)
//
// Optional feature macro: AHB_UART_TX_IRQ_EN (enables CTRL and o_irq).
//
// Ports:
//   HCLK, HRESETn         clock, synchronous active-low reset
//   HSEL..HREADY          AHB-Lite slave inputs (HSIZE ignored)
//   HRDATA                read data, valid in the data phase
//   HREADYOUT, HRESP      tied to zero-wait-state OKAY
//   o_txd                 registered serial output, idle high
//   o_irq                 registered interrupt (0 unless macro defined)
module ahb_uart_tx #(
  parameter int unsigned FIFO_AW         = 3,
  parameter logic [15:0] DEFAULT_BAUDDIV = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        o_txd,
  output logic        o_irq
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bitidx_q, bitidx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic [15:0]          baud_q, baud_d;
  logic                 ovf_q, ovf_d;
  logic [FIFO_AW-1:0]   wptr_q, wptr_d;
  logic [FIFO_AW-1:0]   rptr_q, rptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [7:0]           mem_q [DEPTH];

  logic                 dp_vld_q;
  logic                 dp_wr_q;
  logic [1:0]           dp_addr_q;

  logic                 fifo_empty, fifo_full, busy, bit_end;
  logic                 wr_data, wr_status, wr_baud;
  logic                 push_ok, pop;
  logic [31:0]          status_word;

  // Bits of the bus that this slave never looks at.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign o_txd     = txd_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign busy       = (state_q != S_IDLE);
  assign bit_end    = (cnt_q == 16'd0);

  // Data-phase write decode from the registered address phase.
  assign wr_data   = dp_vld_q && dp_wr_q && (dp_addr_q == 2'd0);
  assign wr_status = dp_vld_q && dp_wr_q && (dp_addr_q == 2'd1);
  assign wr_baud   = dp_vld_q && dp_wr_q && (dp_addr_q == 2'd2);

  assign status_word = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, fifo_empty, fifo_full};

  // Serializer next state. o_txd is registered, so txd_d is the level of the
  // bit that starts on the coming edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = baud_q;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bitidx_d = 3'd0;
          cnt_d    = baud_q;
          txd_d    = shift_q[0];
          state_d  = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = baud_q;
          if (bitidx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            txd_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            cnt_d   = baud_q;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and register writes. A full FIFO still takes a byte when
  // the serializer pops in the same cycle.
  always_comb begin
    push_ok = wr_data && (!fifo_full || pop);
    wptr_d  = push_ok ? wptr_q + FIFO_AW'(1) : wptr_q;
    rptr_d  = pop     ? rptr_q + FIFO_AW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Set is evaluated last so a dropped byte wins over a same-cycle clear.
    ovf_d = ovf_q;
    if (wr_status && HWDATA[3]) ovf_d = 1'b0;
    if (wr_data && !push_ok)    ovf_d = 1'b1;
    baud_d = wr_baud ? HWDATA[15:0] : baud_q;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= DEFAULT_BAUDDIV;
      dp_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      dp_vld_q <= HSEL && HREADY && HTRANS[1];
    end
  end

  // Datapath registers: always loaded before use, so no reset needed.
  always_ff @(posedge HCLK) begin
    cnt_q     <= cnt_d;
    bitidx_q  <= bitidx_d;
    shift_q   <= shift_d;
    dp_wr_q   <= HWRITE;
    dp_addr_q <= HADDR[3:2];
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wptr_q] <= HWDATA[7:0];
  end

`ifdef AHB_UART_TX_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (dp_vld_q && dp_wr_q && (dp_addr_q == 2'd3)) ctrl_d = HWDATA[1:0];
    irq_d = (ctrl_q[0] && fifo_empty && (state_q == S_IDLE)) || (ctrl_q[1] && ovf_q);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

  // Read data follows the registered offset for the whole data phase.
  always_comb begin
    HRDATA = 32'h0;
    if (dp_vld_q && !dp_wr_q) begin
      case (dp_addr_q)
        2'd1:    HRDATA = status_word;
        2'd2:    HRDATA = {16'h0, baud_q};
`ifdef AHB_UART_TX_IRQ_EN
        2'd3:    HRDATA = {30'h0, ctrl_q};
`endif
        default: HRDATA = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_uart_tx.sv
module tb_ahb_uart_tx;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        o_txd;
  logic        o_irq;

  int total = 0;
  int bad   = 0;

`ifdef AHB_UART_TX_IRQ_EN
  localparam logic [31:0] CTRL_EXP = 32'h3;
`else
  localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

  ahb_uart_tx dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .o_txd     (o_txd),
    .o_irq     (o_irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Address phase in the cycle after the next edge, data phase one cycle later.
  // Returns 1 time unit into the data-phase cycle.
  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'(a);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'(a);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Called in the data-phase cycle N of the DATA write. Expects idle in N+1,
  // then the frame from N+2; frame positions below split last d0 cycles,
  // the rest d1 cycles; then idle.
  task automatic check_wave(input logic [7:0] b, input int d0, input int d1,
                            input int split, input string nm);
    @(posedge HCLK); #1;
    chk($sformatf("%s_lat", nm), 32'(o_txd), 32'h1);
    for (int pos = 0; pos < 10; pos++) begin
      for (int k = 0; k < ((pos < split) ? d0 : d1); k++) begin
        @(posedge HCLK); #1;
        chk($sformatf("%s_pos%0d_c%0d", nm, pos, k), 32'(o_txd), 32'(fbit(b, pos)));
      end
    end
    @(posedge HCLK); #1;
    chk($sformatf("%s_idle", nm), 32'(o_txd), 32'h1);
  endtask

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;   // write data, or expected read data
  } reg_vec_t;

  typedef struct packed {
    logic [15:0] baud;
    logic [7:0]  b;
  } frm_vec_t;

  reg_vec_t    rv [12];
  frm_vec_t    fv [3];
  logic [31:0] rd;
  logic [7:0]  b2b [2];

  initial begin
    rv[0]  = '{1'b0, 4'h4, 32'h0000_0002};
    rv[1]  = '{1'b0, 4'h8, 32'd433};
    rv[2]  = '{1'b0, 4'h0, 32'h0000_0000};
    rv[3]  = '{1'b0, 4'hC, 32'h0000_0000};
    rv[4]  = '{1'b1, 4'h8, 32'hABCD_1234};
    rv[5]  = '{1'b0, 4'h8, 32'h0000_1234};
    rv[6]  = '{1'b1, 4'hC, 32'hFFFF_FFFF};
    rv[7]  = '{1'b0, 4'hC, CTRL_EXP};
    rv[8]  = '{1'b1, 4'hC, 32'h0000_0000};
    rv[9]  = '{1'b0, 4'hC, 32'h0000_0000};
    rv[10] = '{1'b1, 4'h4, 32'h0000_0008};
    rv[11] = '{1'b0, 4'h4, 32'h0000_0002};

    fv[0] = '{16'd3, 8'h55};
    fv[1] = '{16'd0, 8'h80};
    fv[2] = '{16'd1, 8'hC3};

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_txd", 32'(o_txd), 32'h1);
    chk("rst_irq", 32'(o_irq), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("hreadyout", 32'(HREADYOUT), 32'h1);
    chk("hresp", 32'(HRESP), 32'h0);
    HRESETn = 1'b1;

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (rv[i].wr) begin
        ahb_write(rv[i].addr, rv[i].data);
      end else begin
        ahb_read(rv[i].addr, rd);
        chk($sformatf("reg%0d_a%0h", i, rv[i].addr), rd, rv[i].data);
      end
    end

    // Single-frame table
    for (int i = 0; i < 3; i++) begin
      ahb_write(4'h8, 32'(fv[i].baud));
      ahb_write(4'h0, 32'(fv[i].b));
      check_wave(fv[i].b, int'(fv[i].baud) + 1, int'(fv[i].baud) + 1, 10,
                 $sformatf("frm%0d", i));
      ahb_read(4'h4, rd);
      chk($sformatf("frm%0d_status", i), rd, 32'h0000_0002);
    end

    // BAUDDIV 3 -> 7 written during data bit 2 (frame position 3)
    ahb_write(4'h8, 32'd3);
    ahb_write(4'h0, 32'h96);
    fork
      check_wave(8'h96, 4, 8, 4, "bdchg");
      begin
        repeat (12) @(posedge HCLK);
        ahb_write(4'h8, 32'd7);
        ahb_read(4'h4, rd);
        chk("busy_mid", rd, 32'h0000_0006);
      end
    join

    // Back-to-back frames at one cycle per bit
    b2b[0] = 8'hA5;
    b2b[1] = 8'h0F;
    ahb_write(4'h8, 32'd0);
    ahb_write(4'h0, 32'(b2b[0]));
    ahb_write(4'h0, 32'(b2b[1]));
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("b2b_c%0d", i), 32'(o_txd), 32'(fbit(b2b[i / 10], i % 10)));
      @(posedge HCLK); #1;
    end
    chk("b2b_idle", 32'(o_txd), 32'h1);

`ifdef AHB_UART_TX_IRQ_EN
    ahb_write(4'hC, 32'h1);
    repeat (2) begin @(posedge HCLK); #1; end
    chk("irq_idle_on", 32'(o_irq), 32'h1);
    ahb_write(4'h0, 32'h3C);
    repeat (3) begin @(posedge HCLK); #1; end
    chk("irq_busy_off", 32'(o_irq), 32'h0);
    repeat (9) begin @(posedge HCLK); #1; end
    chk("irq_pre_done", 32'(o_irq), 32'h0);
    @(posedge HCLK); #1;
    chk("irq_done", 32'(o_irq), 32'h1);
    ahb_write(4'hC, 32'h0);
    repeat (2) begin @(posedge HCLK); #1; end
    chk("irq_disabled", 32'(o_irq), 32'h0);
`endif

    // Overflow: first byte pops, eight fill the FIFO, tenth is dropped
    ahb_write(4'h8, 32'd1000);
    for (int i = 0; i < 10; i++) ahb_write(4'h0, 32'(8'h10 + i));
    ahb_read(4'h4, rd);
    chk("ovf_status", rd, 32'h0000_080D);
    ahb_write(4'h4, 32'h8);
    ahb_read(4'h4, rd);
    chk("ovf_cleared", rd, 32'h0000_0805);
    chk("pre_rst_txd", 32'(o_txd), 32'h0);

    // Reset in the middle of a frame
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk("midrst_txd", 32'(o_txd), 32'h1);
    HRESETn = 1'b1;
    ahb_read(4'h4, rd);
    chk("midrst_status", rd, 32'h0000_0002);
    ahb_read(4'h8, rd);
    chk("midrst_baud", rd, 32'd433);
    repeat (3) begin @(posedge HCLK); #1; end
    chk("midrst_txd_hold", 32'(o_txd), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
